ap_lut_sequencer: RTL and testbench

- Drives a CAM array through bit-serial associative-processing passes: in-place A = f(A, B, carry), one operand bit per iteration.
- For every bit, runs a programmable list of compare/write passes.
  - Compare: drives a key/mask and captures the CAM's tag vector.
  - Write: feeds the captured tags back as parallel write-enables (CAM mode 1).
- Sits directly upstream of the CAM. Drives its key, mask, data, mode and write-enable inputs, and consumes its tags output.

---
 rtl/ap_lut_sequencer.sv | 149 ++++++++++++++
 tb/tb_ap_lut_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ap_lut_sequencer.sv
// Bit-serial associative-processing sequencer: per operand bit, replays a programmable list of CAM compare/write passes.
// Start to done takes 1 + OPND_BITS*np*2 cycles, plus a one-cycle DONE. start and table writes are ignored while busy.
module ap_lut_sequencer #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 128,
  parameter int OPND_BITS  = 3,
  localparam int BW        = (OPND_BITS > 1) ? $clog2(OPND_BITS) : 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            num_passes,
  input  logic                  lut_we,
  input  logic [2:0]            lut_addr,
  input  logic [4:0]            lut_data,
  input  logic [CELL_QUANT-1:0] tags,
  output logic [WORD_SIZE-1:0]  key_v,
  output logic [WORD_SIZE-1:0]  mask_v,
  output logic [WORD_SIZE-1:0]  key_h,
  output logic [WORD_SIZE-1:0]  mask_h,
  output logic                  direction,
  output logic [WORD_SIZE-1:0]  dina,
  output logic                  cam_mode,
  output logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bit_idx
);

  localparam int CB = WORD_SIZE - 1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_CMP, S_WR, S_DONE} state_t;

  state_t                state_q;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            pass_q, pass_d;
  logic [3:0]            np_q;
  logic [CELL_QUANT-1:0] tag_q;
  logic [4:0]            lut_q [8];
  logic [WORD_SIZE-1:0]  key_q, mask_q, dina_q;
  logic                  mode_q, busy_q, done_q;
  logic                  last_pass, last_bit;
  logic [4:0]            cmp_ent, wr_ent;

  // Word with the carry bit, bit OPND_BITS+i (B) and bit i (A) set to c/b/a.
  function automatic logic [WORD_SIZE-1:0] sel_bits(input logic c, input logic b,
                                                    input logic a, input logic [BW-1:0] i);
    logic [WORD_SIZE-1:0] v;
    v = '0;
    v[CB] = c;
    v[OPND_BITS + int'(i)] = b;
    v[int'(i)] = a;
    return v;
  endfunction

  always_comb begin
    last_pass = ({1'b0, pass_q} == (np_q - 4'd1));
    last_bit  = (bit_q == BW'(OPND_BITS - 1));
    pass_d    = '0;
    bit_d     = '0;
    if (state_q == S_WR) begin
      pass_d = last_pass ? 3'd0 : pass_q + 3'd1;
      bit_d  = last_pass ? bit_q + 1'b1 : bit_q;
    end
    cmp_ent = lut_q[pass_d];
    wr_ent  = lut_q[pass_q];
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      pass_q  <= '0;
      np_q    <= '0;
      tag_q   <= '0;
      key_q   <= '0;
      mask_q  <= '0;
      dina_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 8; k++) lut_q[k] <= '0;
    end else begin
      if (lut_we && !busy_q) lut_q[lut_addr] <= lut_data;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_INIT;
            np_q    <= (num_passes > 4'd8) ? 4'd8 : num_passes;
            bit_q   <= '0;
            pass_q  <= '0;
            tag_q   <= '1;  // tag_q doubles as the row write-enable register
            key_q   <= '0;
            mask_q  <= sel_bits(1'b1, 1'b0, 1'b0, '0);
            dina_q  <= '0;
            mode_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_CMP: begin
          state_q <= S_WR;
          tag_q   <= tags;
          key_q   <= '0;
          mask_q  <= sel_bits(1'b1, 1'b0, 1'b1, bit_q);
          dina_q  <= sel_bits(wr_ent[1], 1'b0, wr_ent[0], bit_q);
          mode_q  <= 1'b1;
        end
        S_INIT, S_WR: begin
          if ((state_q == S_INIT && np_q == 4'd0) || (state_q == S_WR && last_pass && last_bit)) begin
            state_q <= S_DONE;
            bit_q   <= '0;
            pass_q  <= '0;
            tag_q   <= '0;
            key_q   <= '0;
            mask_q  <= '0;
            dina_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_CMP;
            bit_q   <= bit_d;
            pass_q  <= pass_d;
            tag_q   <= '0;
            key_q   <= sel_bits(cmp_ent[4], cmp_ent[3], cmp_ent[2], bit_d);
            mask_q  <= sel_bits(1'b1, 1'b1, 1'b1, bit_d);
            dina_q  <= '0;
            mode_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_v            = key_q;
  assign mask_v           = mask_q;
  assign dina             = dina_q;
  assign cam_mode         = mode_q;
  assign cell_wea_ctrl_ap = tag_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign bit_idx          = bit_q;
  assign key_h            = '0;
  assign mask_h           = '0;
  assign direction        = 1'b0;

endmodule

// File: tb/tb_ap_lut_sequencer.sv
// Directed bench for ap_lut_sequencer driving a behavioural CAM that performs the bit-serial add A=A+B.
module tb_ap_lut_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   num_passes;
  logic         lut_we;
  logic [2:0]   lut_addr;
  logic [4:0]   lut_data;
  logic [127:0] tags;
  logic [7:0]   key_v, mask_v, key_h, mask_h, dina;
  logic         direction, cam_mode, busy, done;
  logic [127:0] cell_wea_ctrl_ap;
  logic [1:0]   bit_idx;

  int errors = 0;
  int checks = 0;

  logic [7:0]   mem [128];
  logic         cam_init = 1'b0;

  ap_lut_sequencer dut (
    .CLK100MHZ(clk), .rst(rst), .start(start), .num_passes(num_passes),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data), .tags(tags),
    .key_v(key_v), .mask_v(mask_v), .key_h(key_h), .mask_h(mask_h),
    .direction(direction), .dina(dina), .cam_mode(cam_mode),
    .cell_wea_ctrl_ap(cell_wea_ctrl_ap), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: masked compare gives tags, masked write on rows whose enable is set.
  always_comb begin
    tags = '0;
    for (int r = 0; r < 128; r++) tags[r] = (((mem[r] ^ key_v) & mask_v) == 8'h00);
  end

  always @(posedge clk) begin
    if (cam_init) begin
      for (int r = 0; r < 128; r++) mem[r] <= 8'h00;
      mem[0] <= 8'h93;  // A=3 B=2, stale carry=1 that INIT must clear
      mem[1] <= 8'h0F;  // A=7 B=1
      mem[2] <= 8'h00;  // A=0 B=0
    end else if (cam_mode) begin
      for (int r = 0; r < 128; r++)
        if (cell_wea_ctrl_ap[r]) mem[r] <= (mem[r] & ~mask_v) | (dina & mask_v);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [2:0] a, input logic [4:0] d);
    lut_we = 1'b1; lut_addr = a; lut_data = d;
    tick();
    lut_we = 1'b0;
  endtask

  task automatic load_add;
    load_entry(3'd0, 5'b01110);
    load_entry(3'd1, 5'b01001);
    load_entry(3'd2, 5'b10001);
    load_entry(3'd3, 5'b10110);
  endtask

  task automatic reset_cam;
    cam_init = 1'b1;
    tick();
    cam_init = 1'b0;
  endtask

  // Returns with the DUT in INIT; the cycle count is then 1.
  task automatic start_op(input logic [3:0] np);
    start = 1'b1; num_passes = np;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc, output logic busy_drop);
    busy_drop = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      cyc++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_drop = 1'b1;
    end
  endtask

  int           cyc;
  logic         bdrop;
  logic         saw_done;
  logic [127:0] tags_snap;

  initial begin
    rst = 1'b0; start = 1'b0; num_passes = '0; lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    #3;
    check("reset_outs", {key_v, mask_v, dina, key_h, mask_h, direction, cam_mode, busy, done, bit_idx}, '0);
    check("reset_wea", cell_wea_ctrl_ap, '0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // np=0: INIT then DONE
    start_op(4'd0);
    check("np0_init_wea", cell_wea_ctrl_ap, {128{1'b1}});
    check("np0_init_ctl", {cam_mode, busy, mask_v, dina, key_v}, {1'b1, 1'b1, 8'h80, 8'h00, 8'h00});
    tick();
    check("np0_done", {done, busy}, 2'b10);
    tick();
    check("np0_done_pulse", {done, busy}, 2'b00);

    // ADD table, np=4: first CMP/WR detail and end-to-end result
    load_add();
    reset_cam();
    start_op(4'd4);
    cyc = 1;
    tick(); cyc++;
    check("add_cmp0", {key_v, mask_v, cam_mode, bit_idx}, {8'h09, 8'h89, 1'b0, 2'd0});
    check("add_cmp0_wea", cell_wea_ctrl_ap, '0);
    tags_snap = tags;
    check("add_cmp0_tags", tags_snap, 128'h2);
    tick(); cyc++;
    check("add_wr0", {dina, mask_v, key_v, cam_mode}, {8'h80, 8'h81, 8'h00, 1'b1});
    check("add_wr0_wea", cell_wea_ctrl_ap, tags_snap);
    wait_done(cyc, bdrop);
    check("add_latency", cyc, 26);
    check("add_busy_held", bdrop, 1'b0);
    tick();
    check("add_done_pulse", done, 1'b0);
    check("add_row0", mem[0], 8'h15);
    check("add_row1", mem[1], 8'h88);
    check("add_row2", mem[2], 8'h00);
    check("add_row3", mem[3], 8'h00);

    // np=12 clamps to 8; start and table write mid-run must be ignored
    reset_cam();
    start_op(4'd12);
    cyc = 1;
    tick(); cyc++;
    tick(); cyc++;
    start = 1'b1; lut_we = 1'b1; lut_addr = 3'd0; lut_data = 5'h1F;
    tick(); cyc++;
    start = 1'b0; lut_we = 1'b0;
    wait_done(cyc, bdrop);
    check("np12_latency", cyc, 50);
    check("np12_busy_held", bdrop, 1'b0);
    check("np12_row0", mem[0], 8'h15);
    check("np12_row1", mem[1], 8'h88);
    check("np12_row2", mem[2], 8'h00);
    tick();

    // Reset during WR: immediate zero outputs, no done, table cleared
    start_op(4'd4);
    tick();
    check("tbl_kept_cmp0", key_v, 8'h09);
    tick();
    check("pre_rst_wr", cam_mode, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_outs", {key_v, mask_v, dina, cam_mode, busy, done, bit_idx}, '0);
    check("rst_mid_wea", cell_wea_ctrl_ap, '0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check("rst_no_done", saw_done, 1'b0);
    rst = 1'b1;
    tick();
    start_op(4'd1);
    check("post_rst_init", {busy, mask_v}, {1'b1, 8'h80});
    cyc = 1;
    tick(); cyc++;
    check("post_rst_cmp0", {key_v, mask_v}, {8'h00, 8'h89});
    wait_done(cyc, bdrop);
    check("post_rst_latency", cyc, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
